// File: rtl/sumador_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and digit width.
package sumador_pkg;
    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUMA = 2'd1,
        FIN  = 2'd2
    } state_t;
endpackage

// File: rtl/sumador_nibble.sv
// Combinational single-digit adder: two 4-bit digits plus carry-in to a 5-bit sum.
module sumador_nibble
    import sumador_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_a,
    input  logic [DIGIT_W-1:0] i_b,
    input  logic               i_ci,
    output logic [DIGIT_W:0]   o_s
);
    assign o_s = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT_W{1'b0}}, i_ci};
endmodule

// File: rtl/sumador_serie16.sv
// Digit-serial adder: one 4-bit digit pair per cycle, LSB first, through a single shared
// nibble adder. Fixed latency of NIBBLES+1 cycles from accepted start to the done pulse.
module sumador_serie16
    import sumador_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [DIGIT_W*NIBBLES-1:0] a,
    input  logic [DIGIT_W*NIBBLES-1:0] b,
    input  logic                       Ci,
    output logic                       busy,
    output logic                       done,
    output logic [DIGIT_W*NIBBLES:0]   Y
);
    localparam int W     = DIGIT_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic               r_done;
    logic [W:0]         r_y;
    logic [DIGIT_W-1:0] w_da;
    logic [DIGIT_W-1:0] w_db;
    logic [DIGIT_W:0]   w_sum;
    logic               w_last;

    assign w_last = (r_idx == IDX_W'(NIBBLES - 1));
    assign done   = r_done;
    assign Y      = r_y;

    // Adder operands are selected from the captured registers only, never from the ports.
    always_comb begin
        w_da = '0;
        w_db = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_da = r_a[DIGIT_W*k +: DIGIT_W];
                w_db = r_b[DIGIT_W*k +: DIGIT_W];
            end
        end
    end

    sumador_nibble u_nibble (
        .i_a  (w_da),
        .i_b  (w_db),
        .i_ci (r_carry),
        .o_s  (w_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_next = SUMA;
            end
            SUMA: begin
                busy = 1'b1;
                if (w_last) w_next = FIN;
            end
            FIN: begin
                busy   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // done is registered out of FIN so it lands in the first IDLE cycle, where a new start
    // may already be presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_y     <= '0;
        end else begin
            r_done <= (r_state == FIN);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= Ci;
                        r_idx   <= '0;
                        r_y     <= '0;
                    end
                end
                SUMA: begin
                    r_carry <= w_sum[DIGIT_W];
                    for (int k = 0; k < NIBBLES; k++) begin
                        if (r_idx == IDX_W'(k)) r_y[DIGIT_W*k +: DIGIT_W] <= w_sum[DIGIT_W-1:0];
                    end
                    if (w_last) begin
                        r_y[W] <= w_sum[DIGIT_W];
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sumador_serie16.sv
// Directed bench for sumador_serie16: vector table plus hand-written multi-cycle sequences.
module tb_sumador_serie16;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        Ci;
    logic        busy;
    logic        done;
    logic [16:0] Y;

    int n_pass;
    int n_tot;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [16:0] y;
    } vec_t;

    vec_t vecs [7];

    sumador_serie16 #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .Ci    (Ci),
        .busy  (busy),
        .done  (done),
        .Y     (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Called at a negedge; start is sampled on the next posedge (edge 0), returns at the negedge after it.
    task automatic do_start(input logic [15:0] va, input logic [15:0] vb, input logic vci);
        a     = va;
        b     = vb;
        Ci    = vci;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = 16'h5A5A;
        b     = 16'hA5A5;
        Ci    = 1'b1;
    endtask

    // Counts edges since edge 0 until done is seen; -1 if it never arrives.
    task automatic wait_done(input int from, output int lat);
        int cnt;
        cnt = from;
        lat = -1;
        while (cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (done) begin
                lat = cnt;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int ndone;
        logic [16:0] y_seen;

        n_pass = 0;
        n_tot  = 0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        Ci     = 1'b0;
        rst_n  = 1'b1;

        vecs[0] = '{16'h0001, 16'hFFFF, 1'b0, 17'h10000};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 17'h10000};
        vecs[2] = '{16'h1234, 16'h4321, 1'b0, 17'h05555};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 17'h00000};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE};
        vecs[5] = '{16'hABCD, 16'h1234, 1'b1, 17'h0BE02};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_Y", 32'(Y), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            do_start(vecs[i].a, vecs[i].b, vecs[i].ci);
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            wait_done(0, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("v%0d_Y", i), 32'(Y), 32'(vecs[i].y));
            @(negedge clk);
            check($sformatf("v%0d_done_1cyc", i), 32'(done), 32'd0);
            check($sformatf("v%0d_Y_hold", i), 32'(Y), 32'(vecs[i].y));
        end

        // Y is cleared on accept and the low digit appears after the first SUMA cycle.
        do_start(16'h1234, 16'h4321, 1'b0);
        check("clr_Y", 32'(Y), 32'd0);
        @(negedge clk);
        check("digit0_Y", 32'(Y), 32'h5);
        wait_done(1, lat);
        check("digit_latency", 32'(lat), 32'd5);
        check("digit_Y", 32'(Y), 32'h05555);

        // Back-to-back: new start presented in the cycle done is high.
        do_start(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done(0, lat);
        check("b2b_latency", 32'(lat), 32'd5);
        check("b2b_Y", 32'(Y), 32'h1FFFF);
        @(negedge clk);

        // Start while busy is ignored.
        do_start(16'h0F0F, 16'h00F1, 1'b0);
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        Ci    = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_ign_busy", 32'(busy), 32'd1);
        ndone  = 0;
        y_seen = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                y_seen = Y;
            end
        end
        check("busy_ign_ndone", 32'(ndone), 32'd1);
        check("busy_ign_Y", 32'(y_seen), 32'h01000);

        // Reset in the second SUMA cycle aborts the operation.
        do_start(16'h1234, 16'h4321, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_Y", 32'(Y), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("rst_mid_nodone", 32'(ndone), 32'd0);
        do_start(16'hABCD, 16'h1234, 1'b1);
        wait_done(0, lat);
        check("rst_after_latency", 32'(lat), 32'd5);
        check("rst_after_Y", 32'(Y), 32'h0BE02);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
